// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port 32K x 48 data memory between the CPU data port (A) and
// the debug/DMA port (B). Requests are serialised through a four-state FSM
// (IDLE -> ISSUE -> WAIT -> DONE), so at most one access is accepted every
// four cycles. Simultaneous requests are resolved by a one-bit round-robin
// pointer that always moves to the port that did not win the last grant.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   i_a_read, i_a_write   port A request levels, held until o_a_done
//   i_a_addr, i_a_data    port A word address / write data
//   o_a_data, o_a_done    port A read data (held until next A read) / done pulse
//   i_b_* / o_b_*         same as port A, for port B
//   o_m_addr, o_m_data    memory address / write data (registered, held)
//   o_m_read, o_m_write   memory strobes, one cycle per access
//   i_m_data, i_m_done    memory read data / completion
//   o_busy                high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 15,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          reset_n,
  // port A
  input  logic          i_a_read,
  input  logic          i_a_write,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic [DW-1:0] o_a_data,
  output logic          o_a_done,
  // port B
  input  logic          i_b_read,
  input  logic          i_b_write,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic [DW-1:0] o_b_data,
  output logic          o_b_done,
  // memory side
  output logic [AW-1:0] o_m_addr,
  output logic          o_m_read,
  output logic          o_m_write,
  output logic [DW-1:0] o_m_data,
  input  logic [DW-1:0] i_m_data,
  input  logic          i_m_done,
  // status
  output logic          o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  // Port id encoding used throughout: 0 = A, 1 = B.
  logic          r_ptr;        // preferred port on a tie
  logic          r_owner;      // port that owns the access in flight
  logic          r_op_write;   // 1 = write, 0 = read
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_data;
  logic          r_m_read;
  logic          r_m_write;

  // Per-port views of the request inputs so the port logic can be generated.
  logic [1:0]    w_rd;
  logic [1:0]    w_wr;
  logic [1:0]    w_req;
  logic [1:0]    w_done;
  logic [DW-1:0] w_rdata [2];

  // FSM decode strobes
  logic          w_grant_en;   // IDLE with a request: latch the winner
  logic          w_capture;    // WAIT with memory completion
  logic          w_grant_b;    // winner of the current arbitration is B
  logic          w_sel_write;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;

  assign w_rd = {i_b_read,  i_a_read};
  assign w_wr = {i_b_write, i_a_write};

  // ---------------------------------------------------------------------------
  // Arbitration: B wins only when it requests and either A is silent or the
  // pointer prefers B. A read+write request is treated as a write.
  // ---------------------------------------------------------------------------
  assign w_grant_b   = w_req[1] & (~w_req[0] | r_ptr);
  assign w_sel_write = w_grant_b ? w_wr[1]  : w_wr[0];
  assign w_sel_addr  = w_grant_b ? i_b_addr : i_a_addr;
  assign w_sel_data  = w_grant_b ? i_b_data : i_a_data;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decode. Requests are looked at only in IDLE and
  // memory completions only in WAIT; anything else is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_grant_en   = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_grant_en   = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_m_done) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latched request and memory-side outputs. The strobe is registered at the
  // grant so that it is high exactly during ISSUE; address and data stay
  // held afterwards until the next grant.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_op_write <= 1'b0;
      r_m_addr   <= '0;
      r_m_data   <= '0;
      r_m_read   <= 1'b0;
      r_m_write  <= 1'b0;
    end else begin
      r_m_read  <= w_grant_en & ~w_sel_write;
      r_m_write <= w_grant_en &  w_sel_write;
      if (w_grant_en) begin
        r_owner    <= w_grant_b;
        r_ptr      <= ~w_grant_b;
        r_op_write <= w_sel_write;
        r_m_addr   <= w_sel_addr;
        r_m_data   <= w_sel_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port completion and read-data registers. Only the owner of the access
  // sees a done pulse, and only a read updates its data register.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PORT_ID = 1'(gi);

    logic          r_done;
    logic [DW-1:0] r_rdata;
    logic          w_mine;

    assign w_req[gi] = w_rd[gi] | w_wr[gi];
    assign w_mine    = (r_owner == PORT_ID);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_done  <= 1'b0;
        r_rdata <= '0;
      end else begin
        r_done <= w_capture & w_mine;
        if (w_capture & w_mine & ~r_op_write) begin
          r_rdata <= i_m_data;
        end
      end
    end

    assign w_done[gi]  = r_done;
    assign w_rdata[gi] = r_rdata;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_a_done  = w_done[0];
  assign o_b_done  = w_done[1];
  assign o_a_data  = w_rdata[0];
  assign o_b_data  = w_rdata[1];
  assign o_m_addr  = r_m_addr;
  assign o_m_data  = r_m_data;
  assign o_m_read  = r_m_read;
  assign o_m_write = r_m_write;
  assign o_busy    = (r_state != S_IDLE);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 32K×48 data memory between the CPU data port (port A) and the debug/DMA port (port B). It sits directly in front of the data memory. It serialises accesses with a round-robin grant, drives one registered single-cycle read or write strobe into the memory, and returns the completion and read data to the requester that owns the access. Each access passes through a four-state FSM, so the arbiter accepts at most one access every four cycles.

## Interface
- AW, 15, address width (word address into data memory)
- DW, 48, data word width
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- i_a_read, i_a_write  in  1 each  port A request levels; held until o_a_done
- i_a_addr  in  AW  port A word address
- i_a_data  in  DW  port A write data
- o_a_data  out  DW  port A read data; valid when o_a_done=1, held until port A's next read completes
- o_a_done  out  1  port A completion pulse, one cycle
- i_b_read, i_b_write, i_b_addr, i_b_data, o_b_data, o_b_done: same as port A, for port B
- o_m_addr  out  AW  memory address
- o_m_read, o_m_write  out  1 each  memory strobes; registered; high for exactly one cycle per access
- o_m_data  out  DW  memory write data
- i_m_data  in  DW  memory read data
- i_m_done  in  1  memory completion; asserted the cycle after a strobe
- o_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - A port requests when its read or write level is high.
  - If a request is present, choose a winner, latch its port id, address, data and op, and go to ISSUE.
  - No request: stay in IDLE.
- Arbitration:
  - A one-bit priority pointer names the preferred port. Reset value: A.
  - If both ports request, the preferred port wins.
  - If only one port requests, it wins regardless of the pointer.
  - After every grant, the pointer moves to the port that did not win.
- Op encoding: if read and write are both high on the winning port, perform a write; no read occurs.
- ISSUE: exactly one of o_m_read or o_m_write is high, with o_m_addr and o_m_data taken from the latched request. Go to WAIT.
- WAIT:
  - Strobes are low.
  - When i_m_done=1: for a read, capture i_m_data into the owner's o_x_data register, then go to DONE.
  - While i_m_done=0: stay in WAIT. There is no timeout.
- DONE:
  - The owner's o_x_done=1 and the other port's done stays 0.
  - Requests are ignored in this cycle; the requester drops its level or presents a new request.
  - Go to IDLE.
- Write completion does not change o_x_data.
- Address 0 is not special in the arbiter; the memory returns 0 for reads of address 0, and the arbiter passes that value through.
- An i_m_done seen in IDLE, ISSUE or DONE is ignored (for example, a stray completion after reset).

## Timing
- Reset values (asynchronous, while reset_n=0):
  - State IDLE; pointer A.
  - o_a_done, o_b_done, o_m_read, o_m_write, o_busy all 0.
  - o_m_addr 0; o_m_data 0; o_a_data 0; o_b_data 0.
- Latency for an uncontended request first seen high in cycle 0:
  - Strobe in cycle 1.
  - Memory i_m_done in cycle 2.
  - o_x_done with read data in cycle 3.
  - IDLE again in cycle 4.
- Throughput: one access per 4 cycles. With both ports requesting continuously, grants alternate A, B, A, B.
- A port that sees done in cycle 3 and still holds its request in cycle 4 is treated as a new request.
- Reset asserted mid-access (ISSUE, WAIT or DONE) aborts the access: no done pulse is produced, and a memory write already strobed stays written.
- Request inputs are sampled only in IDLE. Changing address or data while waiting has no effect on the access in progress.

## Test plan
- Reset release, no requests: all outputs stay 0 and o_busy=0 for 10 cycles.
- Port A writes 48'h0123_4567_89AB to address 5, then reads address 5:
  - First access: o_m_write pulses in cycle 1 and o_a_done pulses in cycle 3.
  - Read: o_a_data=48'h0123_4567_89AB at its done pulse; o_b_done stays 0.
- A and B both read in the same cycle, after reset:
  - A is served first; B's done comes 4 cycles after A's.
  - With requests held continuously, the next grant order is A, B.
- Port B reads address 0 after address 0 was written with all ones: o_b_data=0.
- Port A asserts read and write together: a write is performed; o_m_read never pulses and o_a_data is unchanged.
- Reset pulsed in WAIT, then i_m_done=1 arrives after reset: no done pulse on either port, state stays IDLE, and the next request completes normally.
